// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the 16-bit SDRAM-side access port: fixed read/write latency,
// per-byte writes, and optional periodic refresh windows that stall the arbiter.
module sdram_bram_responder #(
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 2,
  parameter int WRITE_LATENCY  = 1,
  parameter int REFRESH_PERIOD = 0,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic [31:0] adr_i,
  input  logic [15:0] dat_i,
  input  logic [1:0]  sel_i,
  input  logic        acc_i,
  input  logic        we_i,
  output logic [15:0] dat_o,
  output logic        ack_o,
  output logic        idle_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int RC_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [RC_W-1:0] RC_RELOAD = (REFRESH_PERIOD > 0) ? RC_W'(REFRESH_PERIOD - 1) : '0;
  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);
  localparam logic [3:0] RF_LOAD = 4'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_ACK     = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

  logic [15:0]           mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [1:0]            sel_q, sel_d;
  logic [15:0]           wdat_q, wdat_d;
  logic [RC_W-1:0]       rcnt_q, rcnt_d;
  logic                  pend_q, pend_d;
  logic                  ack_q, idle_q;
  logic [15:0]           dat_q;
  logic [3:0]            lat_load_s;
  logic                  expire_s;
  logic                  wr_en_s, rd_en_s;
  logic [ADDR_WIDTH-1:0] ram_idx_s;
  logic                  unused_s;

  assign unused_s = ^{adr_i[31:ADDR_WIDTH+1], adr_i[0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    lat_load_s = we_i ? WR_LOAD : RD_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_REFRESH;
          cnt_d   = RF_LOAD;
        end else if (acc_i) begin
          idx_d   = adr_i[ADDR_WIDTH:1];
          we_d    = we_i;
          sel_d   = sel_i;
          wdat_d  = dat_i;
          cnt_d   = lat_load_s;
          state_d = (lat_load_s == 4'd0) ? ST_ACK : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_REFRESH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Free-running refresh timer; an expiry while a window is already owed collapses into it.
  always_comb begin
    expire_s = 1'b0;
    rcnt_d   = '0;
    if (REFRESH_PERIOD > 0) begin
      expire_s = (rcnt_q == '0);
      rcnt_d   = expire_s ? RC_RELOAD : rcnt_q - RC_W'(1);
    end else begin
      rcnt_d = '0;
    end
    if (pend_q) begin
      pend_d = !(state_q == ST_IDLE);
    end else begin
      pend_d = expire_s;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      wdat_q  <= 16'h0000;
      rcnt_q  <= RC_RELOAD;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      ack_q   <= (state_d == ST_ACK);
      idle_q  <= (state_d == ST_IDLE);
    end
  end

  // Reads fire on the edge entering ACK, writes on the edge leaving it: never both at once.
  assign wr_en_s   = (state_q == ST_ACK) && we_q && !sdram_rst;
  assign rd_en_s   = (state_d == ST_ACK) && !we_d && (state_q != ST_ACK);
  assign ram_idx_s = (state_q == ST_ACK) ? idx_q : idx_d;

  always_ff @(posedge sdram_clk) begin
    if (wr_en_s) begin
      if (sel_q[0]) begin
        mem_q[ram_idx_s][7:0] <= wdat_q[7:0];
      end
      if (sel_q[1]) begin
        mem_q[ram_idx_s][15:8] <= wdat_q[15:8];
      end
    end
    if (sdram_rst) begin
      dat_q <= 16'h0000;
    end else if (rd_en_s) begin
      dat_q <= mem_q[ram_idx_s];
    end
  end

  assign dat_o  = dat_q;
  assign ack_o  = ack_q;
  assign idle_o = idle_q;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench: dut_a uses default latencies with refresh off, dut_b uses
// write latency 3 and a 20-cycle refresh period.
module tb_sdram_bram_responder;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] adr;
  logic [15:0] wdat;
  logic [1:0]  sel;
  logic        we, acc_a, acc_b;
  logic [15:0] dat_a, dat_b;
  logic        ack_a, ack_b, idle_a, idle_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sdram_bram_responder dut_a (
    .sdram_clk(clk), .sdram_rst(rst_a), .adr_i(adr), .dat_i(wdat), .sel_i(sel),
    .acc_i(acc_a), .we_i(we), .dat_o(dat_a), .ack_o(ack_a), .idle_o(idle_a)
  );

  sdram_bram_responder #(.WRITE_LATENCY(3), .REFRESH_PERIOD(20), .REFRESH_CYCLES(4)) dut_b (
    .sdram_clk(clk), .sdram_rst(rst_b), .adr_i(adr), .dat_i(wdat), .sel_i(sel),
    .acc_i(acc_b), .we_i(we), .dat_o(dat_b), .ack_o(ack_b), .idle_o(idle_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at an IDLE-cycle negedge; returns at the following IDLE-cycle negedge.
  task automatic access_a(input logic w, input logic [31:0] a, input logic [15:0] d,
                          input logic [1:0] s, input int lat, input logic [15:0] exp_d,
                          input string tag);
    acc_a = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check({tag, "_ack"}, 32'(ack_a), 32'(k == lat));
    end
    check({tag, "_dat"}, 32'(dat_a), 32'(exp_d));
    acc_a = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; acc_a = 1'b0; acc_b = 1'b0;
    we = 1'b0; adr = 32'h0; wdat = 16'h0; sel = 2'b00;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_idle", 32'(idle_a), 32'd1);
    check("rst_dat", 32'(dat_a), 32'h0);
    check("rst_idle_b", 32'(idle_b), 32'd1);

    access_a(1'b1, 32'h10, 16'hA55A, 2'b11, 1, 16'h0000, "wr10");
    access_a(1'b0, 32'h10, 16'h0000, 2'b11, 2, 16'hA55A, "rd10");

    access_a(1'b1, 32'h20, 16'h1234, 2'b11, 1, 16'hA55A, "pre20");
    access_a(1'b1, 32'h20, 16'hFFEE, 2'b01, 1, 16'hA55A, "wr20_lo");
    access_a(1'b0, 32'h20, 16'h0000, 2'b11, 2, 16'h12EE, "rd20_lo");
    access_a(1'b1, 32'h20, 16'h5600, 2'b10, 1, 16'h12EE, "wr20_hi");
    access_a(1'b0, 32'h20, 16'h0000, 2'b11, 2, 16'h56EE, "rd20_hi");
    access_a(1'b1, 32'h20, 16'hFFFF, 2'b00, 1, 16'h56EE, "wr20_none");
    access_a(1'b0, 32'h20, 16'h0000, 2'b11, 2, 16'h56EE, "rd20_none");

    for (int i = 0; i < 4; i++) begin
      access_a(1'b1, 32'(2 * i), 16'h1000 + 16'(i), 2'b11, 1, 16'h56EE, "pre_burst");
    end
    acc_a = 1'b1; we = 1'b0; sel = 2'b11; adr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst_busy_ack", 32'(ack_a), 32'd0);
      check("burst_busy_idle", 32'(idle_a), 32'd0);
      @(negedge clk);
      check("burst_ack", 32'(ack_a), 32'd1);
      check("burst_dat", 32'(dat_a), 32'h1000 + 32'(i));
      check("burst_ack_idle", 32'(idle_a), 32'd0);
      if (i < 3) adr = 32'(2 * (i + 1));
      else acc_a = 1'b0;
      @(negedge clk);
      check("burst_gap_idle", 32'(idle_a), 32'd1);
      check("burst_gap_ack", 32'(ack_a), 32'd0);
    end

    access_a(1'b1, 32'h800, 16'hBEEF, 2'b11, 1, 16'h1003, "wr_wrap");
    access_a(1'b0, 32'h000, 16'h0000, 2'b11, 2, 16'hBEEF, "rd_wrap");

    acc_a = 1'b1; we = 1'b0; adr = 32'h10;
    @(negedge clk);
    acc_a = 1'b0;
    check("drop_busy_ack", 32'(ack_a), 32'd0);
    @(negedge clk);
    check("drop_ack", 32'(ack_a), 32'd1);
    check("drop_dat", 32'(dat_a), 32'hA55A);
    @(negedge clk);

    // dut_b: reset restarts the refresh timer; first expiry lands 20 edges later.
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    acc_b = 1'b1; we = 1'b1; adr = 32'h40; wdat = 16'hCAFE; sel = 2'b11;
    repeat (2) @(negedge clk);
    check("b_wr_early", 32'(ack_b), 32'd0);
    @(negedge clk);
    check("b_wr_ack", 32'(ack_b), 32'd1);
    acc_b = 1'b0;
    repeat (15) @(negedge clk);
    acc_b = 1'b1; we = 1'b0; adr = 32'h40;
    @(negedge clk);
    check("rf_busy_idle", 32'(idle_b), 32'd0);
    check("rf_busy_ack", 32'(ack_b), 32'd0);
    @(negedge clk);
    check("rf_rd_ack", 32'(ack_b), 32'd1);
    check("rf_rd_dat", 32'(dat_b), 32'hCAFE);
    @(negedge clk);
    check("rf_gap_idle", 32'(idle_b), 32'd1);
    check("rf_gap_ack", 32'(ack_b), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rf_win_idle", 32'(idle_b), 32'd0);
      check("rf_win_ack", 32'(ack_b), 32'd0);
    end
    @(negedge clk);
    check("rf_end_idle", 32'(idle_b), 32'd1);
    @(negedge clk);
    check("rf_next_busy", 32'(idle_b), 32'd0);
    check("rf_next_noack", 32'(ack_b), 32'd0);
    @(negedge clk);
    check("rf_next_ack", 32'(ack_b), 32'd1);
    check("rf_next_dat", 32'(dat_b), 32'hCAFE);
    acc_b = 1'b0;
    @(negedge clk);

    acc_b = 1'b1; we = 1'b1; adr = 32'h40; wdat = 16'h1111; sel = 2'b11;
    @(negedge clk);
    check("rstw_busy_ack", 32'(ack_b), 32'd0);
    check("rstw_busy_idle", 32'(idle_b), 32'd0);
    rst_b = 1'b1; acc_b = 1'b0;
    @(negedge clk);
    check("rstw_ack", 32'(ack_b), 32'd0);
    check("rstw_idle", 32'(idle_b), 32'd1);
    check("rstw_dat", 32'(dat_b), 32'h0);
    rst_b = 1'b0;
    acc_b = 1'b1; we = 1'b0; adr = 32'h40;
    @(negedge clk);
    check("rstw_rd_early", 32'(ack_b), 32'd0);
    @(negedge clk);
    check("rstw_rd_ack", 32'(ack_b), 32'd1);
    check("rstw_rd_dat", 32'(dat_b), 32'hCAFE);
    acc_b = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
